// File: rtl/conv_encoder_punct_pkg.sv
// Shared definitions for the K=3 (7,5) convolutional encoder and its Viterbi decoder.
package conv_encoder_punct_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned PAIR_W  = 2;
  localparam int unsigned PH_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_TAIL1 = 2'd2,
    ST_TAIL2 = 2'd3
  } enc_fsm_e;

  // Generator taps, MSB = current bit u, LSB = oldest state bit s1.
  localparam logic [2:0] G1 = 3'b111;
  localparam logic [2:0] G0 = 3'b101;

  // Rate-3/4 keep pattern per output bit, MSB = phase 0.
  localparam logic [2:0] P1 = 3'b110;
  localparam logic [2:0] P0 = 3'b101;

  localparam logic [STATE_W-1:0] TRELLIS_START = 2'b00;
  localparam logic [PH_W-1:0]    PH_LAST       = 2'd2;

  // Erase mask {p1, p0} for a given puncture phase.
  function automatic logic [PAIR_W-1:0] punct_erase(input logic [PH_W-1:0] ph);
    logic [PAIR_W-1:0] er;
    er = 2'b00;
    case (ph)
      2'd0:    er = {~P1[2], ~P0[2]};
      2'd1:    er = {~P1[1], ~P0[1]};
      2'd2:    er = {~P1[0], ~P0[0]};
      default: er = 2'b00;
    endcase
    return er;
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Encoder core: combinational (7,5) parity and the two-bit shift state.
module conv_enc_core
  import conv_encoder_punct_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                u_i,
  input  logic                step_i,
  input  logic                clear_i,
  output logic [PAIR_W-1:0]   parity_c_o,
  output logic [STATE_W-1:0]  s_o
);

  logic [STATE_W-1:0] s_q, s_d;
  logic [2:0]         taps;

  // Tap vector ordered to match the generator constants: {u, s0, s1}.
  assign taps       = {u_i, s_q[0], s_q[1]};
  assign parity_c_o = {^(G1 & taps), ^(G0 & taps)};
  assign s_o        = s_q;

  // Shift in u on a step; frame end returns the trellis to its start state.
  always_comb begin
    s_d = s_q;
    if (step_i) begin
      s_d = clear_i ? TRELLIS_START : {s_q[0], u_i};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_q <= TRELLIS_START;
    else        s_q <= s_d;
  end

endmodule

// File: rtl/conv_encoder_punct.sv
// Rate-1/2 K=3 convolutional encoder with zero tail and optional rate-3/4 puncturing.
module conv_encoder_punct
  import conv_encoder_punct_pkg::*;
#(
  parameter bit PUNCTURE = 1'b1,
  parameter bit TAIL_EN  = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        in_bit,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [1:0]  parities,
  output logic [1:0]  erase,
  output logic        out_valid,
  output logic        out_last
);

  enc_fsm_e           state_q, state_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [PAIR_W-1:0]  par_q, par_d;
  logic [PAIR_W-1:0]  erase_q, erase_d;
  logic               out_valid_q, out_last_q;
  logic               accept, step, u, last_step;
  logic [PAIR_W-1:0]  parity_c;
  logic [STATE_W-1:0] enc_s;

  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_DATA);
  assign accept   = in_valid & in_ready;

  conv_enc_core u_core (
    .clk        (CLK),
    .rst_n      (RST_N),
    .u_i        (u),
    .step_i     (step),
    .clear_i    (last_step),
    .parity_c_o (parity_c),
    .s_o        (enc_s)
  );

  // Frame sequencing: decides when an encode step happens, its input bit and frame end.
  always_comb begin
    state_d   = state_q;
    step      = 1'b0;
    u         = 1'b0;
    last_step = 1'b0;
    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (accept) begin
          step = 1'b1;
          u    = in_bit;
          if (!in_last) begin
            state_d = ST_DATA;
          end else if (TAIL_EN) begin
            state_d = ST_TAIL1;
          end else begin
            state_d   = ST_IDLE;
            last_step = 1'b1;
          end
        end
      end
      ST_TAIL1: begin
        step    = 1'b1;
        state_d = ST_TAIL2;
      end
      ST_TAIL2: begin
        step      = 1'b1;
        last_step = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Puncture phase and next output pair; idle cycles present a clean 00 pair.
  always_comb begin
    ph_d    = ph_q;
    par_d   = 2'b00;
    erase_d = 2'b00;
    if (step) begin
      if (last_step)             ph_d = 2'd0;
      else if (ph_q == PH_LAST)  ph_d = 2'd0;
      else                       ph_d = ph_q + 2'd1;
      if (PUNCTURE) erase_d = punct_erase(ph_q);
      par_d = parity_c & ~erase_d;
    end
  end

  // FSM, phase and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      ph_q        <= 2'd0;
      par_q       <= 2'b00;
      erase_q     <= 2'b00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      par_q       <= par_d;
      erase_q     <= erase_d;
      out_valid_q <= step;
      out_last_q  <= step & last_step;
    end
  end

  // Punctured bits float so the decoder sees them as undriven; erase flags them.
  assign parities[1] = erase_q[1] ? 1'bz : par_q[1];
  assign parities[0] = erase_q[0] ? 1'bz : par_q[0];
  assign erase       = erase_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;

endmodule
